// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants for the inst/data SRAM request arbiter: source tags and FSM encodings.
package sram_req_arbiter_pkg;

  localparam logic ARB_SRC_INST = 1'b0;
  localparam logic ARB_SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_ST_ARB    = 2'd0,
    ARB_ST_LOCK_I = 2'd1,
    ARB_ST_LOCK_D = 2'd2
  } arb_state_e;

  function automatic arb_state_e lock_state(input logic src);
    if (src == ARB_SRC_DATA) begin
      return ARB_ST_LOCK_D;
    end else begin
      return ARB_ST_LOCK_I;
    end
  endfunction

endpackage

// File: rtl/sram_req_arbiter_order_fifo.sv
// One-bit-wide order FIFO remembering which master owns each outstanding transaction.
module arb_order_fifo #(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_src,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  logic [DEPTH-1:0] mem_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Status flags; a push is refused while full even if a pop happens the same cycle.
  always_comb begin
    full   = (count_r == CNT_W'(DEPTH));
    empty  = (count_r == {CNT_W{1'b0}});
    head   = mem_r[rd_ptr_r];
    push_s = push & ~full;
    pop_s  = pop & ~empty;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_r    <= {DEPTH{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_src;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter sharing one SRAM-like slave between the inst and data masters,
// routing responses back in acceptance order.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_req,
  output logic              sram_wr,
  output logic [1:0]        sram_size,
  output logic [3:0]        sram_wstrb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_addr_ok,
  input  logic              sram_data_ok,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              arb_err
);

  arb_state_e state_r;
  logic       last_grant_r;
  logic       arb_err_r;
  logic       grant_s;
  logic       owner_req_s;
  logic       accept_s;
  logic       pop_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic       fifo_head_s;

  // Grant selection: fixed owner while locked, otherwise alternate on a tie.
  always_comb begin
    grant_s = ~last_grant_r;
    case (state_r)
      ARB_ST_LOCK_I: grant_s = ARB_SRC_INST;
      ARB_ST_LOCK_D: grant_s = ARB_SRC_DATA;
      default: begin
        if (inst_req & data_req) begin
          grant_s = ~last_grant_r;
        end else if (data_req) begin
          grant_s = ARB_SRC_DATA;
        end else if (inst_req) begin
          grant_s = ARB_SRC_INST;
        end else begin
          grant_s = ~last_grant_r;
        end
      end
    endcase
  end

  // Request mux and address handshake; nothing leaves while reset is high.
  always_comb begin
    if (grant_s == ARB_SRC_DATA) begin
      owner_req_s = data_req;
      sram_wr     = data_wr;
      sram_size   = data_size;
      sram_wstrb  = data_wstrb;
      sram_addr   = data_addr;
      sram_wdata  = data_wdata;
    end else begin
      owner_req_s = inst_req;
      sram_wr     = inst_wr;
      sram_size   = inst_size;
      sram_wstrb  = inst_wstrb;
      sram_addr   = inst_addr;
      sram_wdata  = inst_wdata;
    end
    sram_req     = owner_req_s & ~fifo_full_s & ~reset;
    accept_s     = sram_req & sram_addr_ok;
    inst_addr_ok = accept_s & (grant_s == ARB_SRC_INST);
    data_addr_ok = accept_s & (grant_s == ARB_SRC_DATA);
  end

  // Response routing from the head of the order FIFO; read data is broadcast.
  always_comb begin
    pop_s        = sram_data_ok & ~fifo_empty_s & ~reset;
    inst_data_ok = pop_s & (fifo_head_s == ARB_SRC_INST);
    data_data_ok = pop_s & (fifo_head_s == ARB_SRC_DATA);
    inst_rdata   = sram_rdata;
    data_rdata   = sram_rdata;
    arb_err      = arb_err_r;
  end

  // Arbitration FSM, round-robin history and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ARB_ST_ARB;
      last_grant_r <= ARB_SRC_INST;
      arb_err_r    <= 1'b0;
    end else begin
      if (sram_data_ok & fifo_empty_s) begin
        arb_err_r <= 1'b1;
      end else begin
        arb_err_r <= arb_err_r;
      end
      if (accept_s) begin
        last_grant_r <= grant_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
      case (state_r)
        ARB_ST_ARB: begin
          if (sram_req & ~sram_addr_ok) begin
            state_r <= lock_state(grant_s);
          end else begin
            state_r <= ARB_ST_ARB;
          end
        end
        ARB_ST_LOCK_I, ARB_ST_LOCK_D: begin
          // A dropped owner request abandons the lock without recording anything.
          if (accept_s | ~owner_req_s) begin
            state_r <= ARB_ST_ARB;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= ARB_ST_ARB;
      endcase
    end
  end

  arb_order_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_order_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept_s),
    .push_src(grant_s),
    .pop     (pop_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .head    (fifo_head_s)
  );

endmodule
